lsb_stego_encoder: RTL and testbench
====================================

Name: lsb_stego_encoder

Overview:
- Embeds an ASCII message into the least-significant bits of image bytes held in the block RAM, one message bit per image byte, MSB of each character first.
- Appends a 0x00 terminator character so the on-board LSB message extractor stops at the end of the message.
- Sits between a byte-stream message source (UART or a test ROM) and the single-port BRAM (12-bit address, 8-bit data).

Parameters:
- BASE_ADDR, 0: first image byte address used for embedding.
- IMG_BYTES, 4096: number of image bytes available from BASE_ADDR onwards.
- READ_LATENCY, 1: BRAM read latency in cycles (1 or 2).

Ports:
- CLK100MHZ  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins an encode; ignored unless in IDLE.
- msg_byte  in  8  message character.
- msg_valid  in  1  msg_byte/msg_last are valid.
- msg_last  in  1  qualifies the final character of the message.
- msg_ready  out  1  character accepted when msg_valid and msg_ready are both high.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  12  BRAM address.
- bram_din  out  8  BRAM write data.
- bram_dout  in  8  BRAM read data.
- busy  out  1  encode in progress.
- done  out  1  set when an encode finishes; cleared by the next accepted start.
- overflow  out  1  image capacity was exhausted before the terminator was written; cleared by the next accepted start.
- chars_done  out  11  characters fully embedded, terminator included.

Behaviour:
- Reset (asynchronous): state IDLE. All of the following are 0: msg_ready, bram_en, bram_we, bram_addr, bram_din, busy, done, overflow, chars_done. Reset mid-encode aborts immediately with bram_we low; bytes already written stay modified.
- States: IDLE, FETCH, READ, WAIT, WRITE, NEXT, TERM, FINISH.
- IDLE: on start go to FETCH. Set busy=1, clear done, overflow and chars_done, set addr pointer to BASE_ADDR.
- FETCH: msg_ready=1. On handshake, latch the character into the shift register, latch last_flag, set bit index to 7, go to READ. With msg_valid low, stall indefinitely.
- READ: bram_en=1, bram_we=0, bram_addr=pointer. Go to WAIT.
- WAIT: hold for READ_LATENCY cycles, then capture bram_dout. Go to WRITE.
- WRITE: bram_en=1, bram_we=1, same address. bram_din = {captured[7:1], char[bit index]}; the upper 7 bits are always preserved. Go to NEXT.
- NEXT: increment pointer. If bit index > 0, decrement it and go to READ.
- NEXT, on completing a character: increment chars_done. If that character was the terminator, go to FINISH. Else if last_flag is set, load 0x00 as the character and go to TERM. Else go to FETCH.
- TERM: same as FETCH without a handshake; go to READ. msg_ready stays 0.
- Timing: each bit takes 2+READ_LATENCY cycles (READ, WAIT, WRITE) plus 1 cycle in NEXT.
- Capacity check: before every READ, if pointer == BASE_ADDR+IMG_BYTES, set overflow=1 and go to FINISH with no further BRAM access.
- FINISH: busy=0, done=1, go to IDLE.
- start while busy: ignored.
- msg_valid high with msg_ready low: the character is not consumed.
- Pointer arithmetic is 12-bit. Configuration must satisfy BASE_ADDR+IMG_BYTES ≤ 4096; wrap-around is never used.
- bram_en=0 in IDLE, FETCH, TERM, NEXT and FINISH.

Test Plan:
- BRAM pre-filled 0xFF, READ_LATENCY=1. Send "Y" (0x59) with msg_last. Required result:
  - Addresses 0-7 hold FE,FF,FE,FF,FF,FE,FE,FF.
  - Addresses 8-15 hold FE.
  - Address 16 is untouched (0xFF).
  - done=1, chars_done=2, overflow=0.
  - Total cycles from start ≈ 16×4 plus the handshake.
- BRAM pre-filled 0xA4. Send "E" (0x45) with last. Addresses 0-7 hold A4,A5,A4,A4,A4,A5,A4,A5; upper 7 bits are unchanged everywhere.
- Send "YO" with msg_valid dropped for 20 cycles between characters. msg_ready stays high throughout the gap, no BRAM access occurs during it, and the final image equals the no-stall result.
- IMG_BYTES=12. Send "AB". 12 bytes are written, then overflow=1 and done=1; address 12 is never accessed; chars_done=1.
- Assert Reset_n low during bit 3 of a character. bram_we falls immediately; busy=0, done=0, chars_done=0. A following start re-encodes from BASE_ADDR.
- A second start pulse mid-encode has no effect: pointer and chars_done continue undisturbed.

Source files
------------

// File: rtl/lsb_stego_encoder.sv
// -----------------------------------------------------------------------------
// lsb_stego_encoder
//
// Hides an ASCII message in the least-significant bits of an image held in a
// single-port block RAM. Each image byte carries one message bit, and each
// character is sent MSB first. A 0x00 terminator character follows the last
// message character so the extractor knows where the message ends. Every
// embedded bit costs a read-modify-write of one image byte, so the upper seven
// bits of each pixel byte are kept exactly as they were.
//
// Parameters
//   BASE_ADDR     first image byte used for embedding
//   IMG_BYTES     number of image bytes available from BASE_ADDR onwards
//                 (BASE_ADDR + IMG_BYTES must not exceed 4096)
//   READ_LATENCY  BRAM read latency in cycles (1 or 2)
//
// Ports
//   CLK100MHZ     system clock
//   Reset_n       asynchronous active-low reset
//   start         one-cycle pulse that begins an encode (honoured only in IDLE)
//   msg_byte      message character
//   msg_valid     msg_byte / msg_last valid
//   msg_last      marks the final message character
//   msg_ready     character taken when msg_valid && msg_ready
//   bram_en       BRAM enable
//   bram_we       BRAM write enable
//   bram_addr     BRAM address (12 bit)
//   bram_din      BRAM write data
//   bram_dout     BRAM read data
//   busy          encode in progress
//   done          last encode finished (cleared by the next accepted start)
//   overflow      image ran out before the terminator was written
//   chars_done    characters fully embedded, terminator included
// -----------------------------------------------------------------------------
module lsb_stego_encoder #(
   parameter int unsigned BASE_ADDR    = 0,
   parameter int unsigned IMG_BYTES    = 4096,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        CLK100MHZ,
   input  logic        Reset_n,
   input  logic        start,
   input  logic [7:0]  msg_byte,
   input  logic        msg_valid,
   input  logic        msg_last,
   output logic        msg_ready,
   output logic        bram_en,
   output logic        bram_we,
   output logic [11:0] bram_addr,
   output logic [7:0]  bram_din,
   input  logic [7:0]  bram_dout,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [10:0] chars_done
);

   // The pointer carries one extra bit so that the end-of-image limit can be
   // represented even when the image runs right up to address 4095.
   localparam logic [12:0] BASE_PTR  = 13'(BASE_ADDR);
   localparam logic [12:0] LIMIT_PTR = 13'(BASE_ADDR + IMG_BYTES);
   localparam logic [1:0]  WAIT_LAST = 2'(READ_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_NEXT,
      S_TERM,
      S_FINISH
   } state_t;

   state_t      state_q,      state_d;
   logic [12:0] ptr_q,        ptr_d;
   logic [7:0]  char_q,       char_d;
   logic        last_q,       last_d;
   logic        term_q,       term_d;
   logic [2:0]  bit_idx_q,    bit_idx_d;
   logic [1:0]  wait_cnt_q,   wait_cnt_d;
   logic        msg_ready_q,  msg_ready_d;
   logic        bram_en_q,    bram_en_d;
   logic        bram_we_q,    bram_we_d;
   logic [11:0] bram_addr_q,  bram_addr_d;
   logic [7:0]  bram_din_q,   bram_din_d;
   logic        busy_q,       busy_d;
   logic        done_q,       done_d;
   logic        overflow_q,   overflow_d;
   logic [10:0] chars_done_q, chars_done_d;

   // Shared "issue a read" request: every path into READ goes through the
   // capacity check below, so no BRAM access can happen past the image end.
   logic        go_read;
   logic [12:0] rd_ptr;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      char_d       = char_q;
      last_d       = last_q;
      term_d       = term_q;
      bit_idx_d    = bit_idx_q;
      wait_cnt_d   = wait_cnt_q;
      msg_ready_d  = msg_ready_q;
      bram_en_d    = bram_en_q;
      bram_we_d    = bram_we_q;
      bram_addr_d  = bram_addr_q;
      bram_din_d   = bram_din_q;
      busy_d       = busy_q;
      done_d       = done_q;
      overflow_d   = overflow_q;
      chars_done_d = chars_done_q;
      go_read      = 1'b0;
      rd_ptr       = ptr_q;

      case (state_q)
         S_IDLE: begin
            msg_ready_d = 1'b0;
            bram_en_d   = 1'b0;
            bram_we_d   = 1'b0;
            if (start) begin
               busy_d       = 1'b1;
               done_d       = 1'b0;
               overflow_d   = 1'b0;
               chars_done_d = 11'd0;
               ptr_d        = BASE_PTR;
               msg_ready_d  = 1'b1;
               state_d      = S_FETCH;
            end
         end

         S_FETCH: begin
            // Stalls here for as long as the source holds msg_valid low.
            if (msg_valid && msg_ready_q) begin
               char_d      = msg_byte;
               last_d      = msg_last;
               term_d      = 1'b0;
               bit_idx_d   = 3'd7;
               msg_ready_d = 1'b0;
               go_read     = 1'b1;
               rd_ptr      = ptr_q;
            end
         end

         S_READ: begin
            bram_en_d  = 1'b0;
            wait_cnt_d = 2'd0;
            state_d    = S_WAIT;
         end

         S_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               // Keep the pixel's upper seven bits, replace only the LSB.
               bram_din_d    = bram_dout;
               bram_din_d[0] = char_q[bit_idx_q];
               bram_en_d     = 1'b1;
               bram_we_d     = 1'b1;
               state_d       = S_WRITE;
            end else begin
               wait_cnt_d = wait_cnt_q + 2'd1;
            end
         end

         S_WRITE: begin
            bram_en_d = 1'b0;
            bram_we_d = 1'b0;
            state_d   = S_NEXT;
         end

         S_NEXT: begin
            ptr_d = ptr_q + 13'd1;
            if (bit_idx_q != 3'd0) begin
               bit_idx_d = bit_idx_q - 3'd1;
               go_read   = 1'b1;
               rd_ptr    = ptr_q + 13'd1;
            end else begin
               chars_done_d = chars_done_q + 11'd1;
               if (term_q) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_FINISH;
               end else if (last_q) begin
                  char_d  = 8'h00;
                  term_d  = 1'b1;
                  state_d = S_TERM;
               end else begin
                  msg_ready_d = 1'b1;
                  state_d     = S_FETCH;
               end
            end
         end

         S_TERM: begin
            bit_idx_d = 3'd7;
            go_read   = 1'b1;
            rd_ptr    = ptr_q;
         end

         S_FINISH: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (go_read) begin
         ptr_d = rd_ptr;
         if (rd_ptr == LIMIT_PTR) begin
            // Image exhausted: stop without touching the BRAM again.
            overflow_d  = 1'b1;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            msg_ready_d = 1'b0;
            bram_en_d   = 1'b0;
            bram_we_d   = 1'b0;
            state_d     = S_FINISH;
         end else begin
            bram_en_d   = 1'b1;
            bram_we_d   = 1'b0;
            bram_addr_d = rd_ptr[11:0];
            state_d     = S_READ;
         end
      end
   end

   always_ff @(posedge CLK100MHZ or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= S_IDLE;
         ptr_q        <= BASE_PTR;
         char_q       <= 8'h00;
         last_q       <= 1'b0;
         term_q       <= 1'b0;
         bit_idx_q    <= 3'd0;
         wait_cnt_q   <= 2'd0;
         msg_ready_q  <= 1'b0;
         bram_en_q    <= 1'b0;
         bram_we_q    <= 1'b0;
         bram_addr_q  <= 12'd0;
         bram_din_q   <= 8'h00;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
         chars_done_q <= 11'd0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         char_q       <= char_d;
         last_q       <= last_d;
         term_q       <= term_d;
         bit_idx_q    <= bit_idx_d;
         wait_cnt_q   <= wait_cnt_d;
         msg_ready_q  <= msg_ready_d;
         bram_en_q    <= bram_en_d;
         bram_we_q    <= bram_we_d;
         bram_addr_q  <= bram_addr_d;
         bram_din_q   <= bram_din_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         overflow_q   <= overflow_d;
         chars_done_q <= chars_done_d;
      end
   end

   assign msg_ready  = msg_ready_q;
   assign bram_en    = bram_en_q;
   assign bram_we    = bram_we_q;
   assign bram_addr  = bram_addr_q;
   assign bram_din   = bram_din_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign overflow   = overflow_q;
   assign chars_done = chars_done_q;

endmodule

// File: tb/tb_lsb_stego_encoder.sv
// -----------------------------------------------------------------------------
// tb_lsb_stego_encoder
//
// Two encoder instances share one stimulus port, selected by sel:
//   dut0: BASE_ADDR=0,   IMG_BYTES=4096, READ_LATENCY=1
//   dut1: BASE_ADDR=100, IMG_BYTES=12,   READ_LATENCY=2 (capacity limit)
// Each instance has its own behavioural BRAM. Expected images come from a
// bit-by-bit embedding model working on a message queue.
// -----------------------------------------------------------------------------
module tb_lsb_stego_encoder;

   typedef logic [7:0] byte_q_t [$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start;
   logic       msg_valid;
   logic       msg_last;
   logic [7:0] msg_byte;
   logic       sel;

   logic        start_w [2];
   logic        valid_w [2];
   logic        ready_w [2];
   logic        en_w    [2];
   logic        we_w    [2];
   logic [11:0] addr_w  [2];
   logic [7:0]  din_w   [2];
   logic [7:0]  dout_w  [2];
   logic        busy_w  [2];
   logic        done_w  [2];
   logic        ovf_w   [2];
   logic [10:0] cd_w    [2];

   assign start_w[0] = start & ~sel;
   assign start_w[1] = start & sel;
   assign valid_w[0] = msg_valid & ~sel;
   assign valid_w[1] = msg_valid & sel;

   logic        cur_ready, cur_en, cur_we, cur_busy, cur_done, cur_ovf;
   logic [11:0] cur_addr;
   logic [7:0]  cur_din;
   logic [10:0] cur_cd;
   assign cur_ready = sel ? ready_w[1] : ready_w[0];
   assign cur_en    = sel ? en_w[1]    : en_w[0];
   assign cur_we    = sel ? we_w[1]    : we_w[0];
   assign cur_busy  = sel ? busy_w[1]  : busy_w[0];
   assign cur_done  = sel ? done_w[1]  : done_w[0];
   assign cur_ovf   = sel ? ovf_w[1]   : ovf_w[0];
   assign cur_addr  = sel ? addr_w[1]  : addr_w[0];
   assign cur_din   = sel ? din_w[1]   : din_w[0];
   assign cur_cd    = sel ? cd_w[1]    : cd_w[0];

   lsb_stego_encoder #(.BASE_ADDR(0), .IMG_BYTES(4096), .READ_LATENCY(1)) dut0 (
      .CLK100MHZ (clk),        .Reset_n   (rst_n),
      .start     (start_w[0]), .msg_byte  (msg_byte),
      .msg_valid (valid_w[0]), .msg_last  (msg_last),
      .msg_ready (ready_w[0]), .bram_en   (en_w[0]),
      .bram_we   (we_w[0]),    .bram_addr (addr_w[0]),
      .bram_din  (din_w[0]),   .bram_dout (dout_w[0]),
      .busy      (busy_w[0]),  .done      (done_w[0]),
      .overflow  (ovf_w[0]),   .chars_done(cd_w[0])
   );

   lsb_stego_encoder #(.BASE_ADDR(100), .IMG_BYTES(12), .READ_LATENCY(2)) dut1 (
      .CLK100MHZ (clk),        .Reset_n   (rst_n),
      .start     (start_w[1]), .msg_byte  (msg_byte),
      .msg_valid (valid_w[1]), .msg_last  (msg_last),
      .msg_ready (ready_w[1]), .bram_en   (en_w[1]),
      .bram_we   (we_w[1]),    .bram_addr (addr_w[1]),
      .bram_din  (din_w[1]),   .bram_dout (dout_w[1]),
      .busy      (busy_w[1]),  .done      (done_w[1]),
      .overflow  (ovf_w[1]),   .chars_done(cd_w[1])
   );

   // Behavioural BRAMs
   logic [7:0] mem      [2][4096];
   bit         touched  [2][4096];
   logic [7:0] init_img [4096];
   logic [7:0] ref_img  [4096];
   int         acc_cnt  [2];
   int         wr_cnt   [2];
   logic [7:0] rd1      [2];
   logic [7:0] rd2      [2];
   logic       load_req;
   int         cyc_ctr = 0;

   assign dout_w[0] = rd1[0];
   assign dout_w[1] = rd2[1];

   always @(posedge clk) begin
      cyc_ctr <= cyc_ctr + 1;
      for (int k = 0; k < 2; k++) begin
         rd2[k] <= rd1[k];
         if (load_req) begin
            for (int i = 0; i < 4096; i++) begin
               mem[k][i]     <= init_img[i];
               touched[k][i] <= 1'b0;
            end
            acc_cnt[k] <= 0;
            wr_cnt[k]  <= 0;
         end else if (en_w[k]) begin
            acc_cnt[k]              <= acc_cnt[k] + 1;
            touched[k][addr_w[k]]   <= 1'b1;
            if (we_w[k]) begin
               mem[k][addr_w[k]] <= din_w[k];
               wr_cnt[k]         <= wr_cnt[k] + 1;
            end else begin
               rd1[k] <= mem[k][addr_w[k]];
            end
         end
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic byte_q_t str2q(input string s);
      byte_q_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   task automatic load_mem(input bit rnd, input logic [7:0] val);
      for (int i = 0; i < 4096; i++) begin
         init_img[i] = rnd ? 8'($urandom) : val;
         ref_img[i]  = init_img[i];
      end
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   // Reference: message plus 0x00 terminator, MSB first, one bit per byte,
   // stopping when the image (cap bytes) or max_bits runs out.
   task automatic run_model(input byte_q_t msg, input int base, input int cap,
                            input int max_bits, output int chars, output bit ovf);
      byte_q_t seq;
      int pos;
      seq = msg;
      seq.push_back(8'h00);
      pos = 0; chars = 0; ovf = 1'b0;
      foreach (seq[c]) begin
         for (int b = 7; b >= 0; b--) begin
            if (pos == max_bits) return;
            if (pos == cap) begin
               ovf = 1'b1;
               return;
            end
            ref_img[base + pos][0] = seq[c][b];
            pos++;
         end
         chars++;
      end
   endtask

   task automatic encode(input int s, input byte_q_t msg, input int gap,
                         input bit mid_start, output int cyc);
      int bound, c0, a0, lows;
      bit fin;
      sel = (s != 0);
      fin = 1'b0;
      @(negedge clk);
      start = 1'b1;
      c0 = cyc_ctr;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < msg.size() && !fin; i++) begin
         if (i > 0 && gap > 0) begin
            bound = 0;
            while (!cur_ready && !cur_done && bound < 1000) begin
               @(negedge clk);
               bound++;
            end
            a0 = acc_cnt[s];
            lows = 0;
            repeat (gap) begin
               @(negedge clk);
               if (!cur_ready) lows++;
            end
            chk("gap_ready_low_cycles", 32'(lows), 32'd0);
            chk("gap_bram_accesses", 32'(acc_cnt[s] - a0), 32'd0);
         end
         msg_byte  = msg[i];
         msg_last  = (i == msg.size() - 1);
         msg_valid = 1'b1;
         bound = 0;
         while (!cur_ready && !cur_done && bound < 3000) begin
            @(negedge clk);
            bound++;
         end
         chk("handshake_wait", 32'(cur_ready | cur_done), 32'd1);
         if (cur_done || !cur_ready) begin
            msg_valid = 1'b0;
            fin = 1'b1;
         end else begin
            @(negedge clk);
            msg_valid = 1'b0;
            msg_last  = 1'b0;
            if (i == 0 && mid_start) begin
               repeat (7) @(negedge clk);
               start = 1'b1;
               @(negedge clk);
               start = 1'b0;
               chk("mid_start_busy", 32'(cur_busy), 32'd1);
            end
         end
      end
      bound = 0;
      while (!cur_done && bound < 5000) begin
         @(negedge clk);
         bound++;
      end
      chk("done_wait", 32'(cur_done), 32'd1);
      cyc = cyc_ctr - c0;
   endtask

   task automatic check_all(input string tag, input int s, input int chars, input bit ovf);
      int errs, first;
      errs = 0; first = -1;
      for (int i = 0; i < 4096; i++) begin
         if (mem[s][i] !== ref_img[i]) begin
            if (first < 0) first = i;
            errs++;
         end
      end
      chk({tag, "_done"},       32'(cur_done), 32'd1);
      chk({tag, "_busy"},       32'(cur_busy), 32'd0);
      chk({tag, "_overflow"},   32'(cur_ovf),  32'(ovf));
      chk({tag, "_chars_done"}, 32'(cur_cd),   32'(chars));
      chk({tag, "_img_bad_bytes"}, 32'(errs),  32'd0);
      if (errs != 0) $display("  %s first differing address %0d", tag, first);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      byte_q_t q;
      int      chars, cyc, bound;
      bit      ovf;
      logic [7:0] exp_y [8];
      logic [7:0] exp_e [8];
      exp_y = '{8'hFE, 8'hFF, 8'hFE, 8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFF};
      exp_e = '{8'hA4, 8'hA5, 8'hA4, 8'hA4, 8'hA4, 8'hA5, 8'hA4, 8'hA5};

      rst_n = 1'b0; start = 1'b0; msg_valid = 1'b0; msg_last = 1'b0;
      msg_byte = 8'h00; sel = 1'b0; load_req = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_msg_ready",  32'(cur_ready), 32'd0);
      chk("rst_bram_en",    32'(cur_en),    32'd0);
      chk("rst_bram_we",    32'(cur_we),    32'd0);
      chk("rst_bram_addr",  32'(cur_addr),  32'd0);
      chk("rst_bram_din",   32'(cur_din),   32'd0);
      chk("rst_busy",       32'(cur_busy),  32'd0);
      chk("rst_done",       32'(cur_done),  32'd0);
      chk("rst_overflow",   32'(cur_ovf),   32'd0);
      chk("rst_chars_done", 32'(cur_cd),    32'd0);
      sel = 1'b1;
      chk("rst1_busy",      32'(cur_busy),  32'd0);
      chk("rst1_addr",      32'(cur_addr),  32'd0);
      sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // "Y" into an all-FF image
      load_mem(1'b0, 8'hFF);
      q = str2q("Y");
      run_model(q, 0, 4096, 1 << 20, chars, ovf);
      encode(0, q, 0, 1'b0, cyc);
      for (int i = 0; i < 8; i++) chk($sformatf("y_addr%0d", i), 32'(mem[0][i]), 32'(exp_y[i]));
      for (int i = 8; i < 16; i++) chk($sformatf("y_term_addr%0d", i), 32'(mem[0][i]), 32'hFE);
      chk("y_addr16_untouched", 32'(mem[0][16]), 32'hFF);
      chk("y_chars_done_2", 32'(cur_cd), 32'd2);
      chk("y_cycles_in_64_70", 32'(cyc >= 64 && cyc <= 70), 32'd1);
      check_all("y", 0, chars, ovf);

      // "E" into an all-A4 image
      load_mem(1'b0, 8'hA4);
      q = str2q("E");
      run_model(q, 0, 4096, 1 << 20, chars, ovf);
      encode(0, q, 0, 1'b0, cyc);
      for (int i = 0; i < 8; i++) chk($sformatf("e_addr%0d", i), 32'(mem[0][i]), 32'(exp_e[i]));
      check_all("e", 0, chars, ovf);

      // "YO" with a 20-cycle source stall between characters
      load_mem(1'b1, 8'h00);
      q = str2q("YO");
      run_model(q, 0, 4096, 1 << 20, chars, ovf);
      encode(0, q, 20, 1'b0, cyc);
      check_all("yo_stall", 0, chars, ovf);

      // Capacity limit on the 12-byte instance
      load_mem(1'b1, 8'h00);
      q = str2q("AB");
      run_model(q, 100, 12, 1 << 20, chars, ovf);
      encode(1, q, 0, 1'b0, cyc);
      chk("ovf_flag", 32'(cur_ovf), 32'd1);
      chk("ovf_chars_done_1", 32'(cur_cd), 32'd1);
      chk("ovf_addr112_not_accessed", 32'(touched[1][112]), 32'd0);
      chk("ovf_addr111_accessed", 32'(touched[1][111]), 32'd1);
      chk("ovf_addr99_not_accessed", 32'(touched[1][99]), 32'd0);
      chk("ovf_write_count", 32'(wr_cnt[1]), 32'd12);
      check_all("ovf", 1, chars, ovf);

      // Reset during bit 3 of the first character, then re-encode
      load_mem(1'b1, 8'h00);
      sel = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      msg_byte = 8'h51; msg_last = 1'b0; msg_valid = 1'b1;
      @(negedge clk);
      msg_valid = 1'b0;
      bound = 0;
      while (!(wr_cnt[0] == 4 && we_w[0]) && bound < 500) begin
         @(negedge clk);
         bound++;
      end
      chk("abort_reached_bit3_write", 32'(we_w[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_we_low",      32'(we_w[0]), 32'd0);
      chk("abort_busy",        32'(cur_busy), 32'd0);
      chk("abort_done",        32'(cur_done), 32'd0);
      chk("abort_chars_done",  32'(cur_cd),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_writes_kept", 32'(wr_cnt[0]), 32'd4);
      q = str2q("Q");
      run_model(q, 0, 4096, 4, chars, ovf);
      q = str2q("Hi!");
      run_model(q, 0, 4096, 1 << 20, chars, ovf);
      encode(0, q, 0, 1'b0, cyc);
      check_all("after_abort", 0, chars, ovf);

      // Stray start pulse in the middle of an encode
      load_mem(1'b1, 8'h00);
      q = str2q("MID");
      run_model(q, 0, 4096, 1 << 20, chars, ovf);
      encode(0, q, 0, 1'b1, cyc);
      check_all("mid_start", 0, chars, ovf);

      // Randomised messages, images and stalls
      for (int r = 0; r < 6; r++) begin
         int len, gap, s;
         s   = (r == 5) ? 1 : 0;
         len = $urandom_range(1, 7);
         gap = $urandom_range(0, 3);
         q.delete();
         for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(32, 126)));
         load_mem(1'b1, 8'h00);
         if (s == 1) run_model(q, 100, 12, 1 << 20, chars, ovf);
         else        run_model(q, 0, 4096, 1 << 20, chars, ovf);
         encode(s, q, (s == 1) ? 0 : gap, (r == 2), cyc);
         check_all($sformatf("rand%0d", r), s, chars, ovf);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
